// File: rtl/hv_fuser_pkg.sv
// Shared constants and the modality/state encoding used by the spatial encoder and the fuser.
package hv_fuser_pkg;

    localparam int HV_DIMENSION = 2000;

    // Modality order matches the spatial encoder's beat order: GSR, ECG, EEG.
    typedef enum logic [1:0] {
        COLLECT_GSR = 2'd0,
        COLLECT_ECG = 2'd1,
        COLLECT_EEG = 2'd2,
        HOLD        = 2'd3
    } fuser_state_e;

endpackage

// File: rtl/hv_fuser_majority3.sv
// Bitwise majority-of-3 vote; purely combinational.
module majority3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/hv_fuser.sv
// Fuses per-fold GSR/ECG/EEG beats by bitwise majority into a full-width hypervector
// and hands the result downstream over valid/ready.
//
// state       | meaning
// COLLECT_GSR | waiting for GSR beat of the expected fold
// COLLECT_ECG | waiting for ECG beat
// COLLECT_EEG | waiting for EEG beat; fire writes the fused slice
// HOLD        | fused vector presented; upstream beats are dropped
module hv_fuser #(
    parameter int NUM_FOLDS       = 1,
    parameter int NUM_FOLDS_WIDTH = 1,
    parameter int FOLD_WIDTH      = 2000,
    parameter int HV_DIMENSION    = 2000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       hvin_valid_i,
    output logic                       hvin_ready_o,
    input  logic [FOLD_WIDTH-1:0]      hvin_i,
    input  logic [NUM_FOLDS_WIDTH-1:0] fold_index_i,
    output logic                       hvout_valid_o,
    input  logic                       hvout_ready_i,
    output logic [HV_DIMENSION-1:0]    hvout_o,
    output logic                       overflow_o,
    output logic                       seq_error_o
);

    import hv_fuser_pkg::*;

    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    fuser_state_e                state_q, state_d;
    logic [NUM_FOLDS_WIDTH-1:0]  fold_q, fold_d;
    logic [FOLD_WIDTH-1:0]       gsr_q, gsr_d;
    logic [FOLD_WIDTH-1:0]       ecg_q, ecg_d;
    logic [HV_DIMENSION-1:0]     fused_q, fused_d;
    logic                        overflow_q, overflow_d;
    logic                        seq_error_q, seq_error_d;
    logic [FOLD_WIDTH-1:0]       maj;

    majority3 #(.WIDTH(FOLD_WIDTH)) u_majority3 (
        .a_i   (gsr_q),
        .b_i   (ecg_q),
        .c_i   (hvin_i),
        .maj_o (maj)
    );

    assign hvin_ready_o  = (state_q != HOLD);
    assign hvout_valid_o = (state_q == HOLD);
    assign hvout_o       = fused_q;
    assign overflow_o    = overflow_q;
    assign seq_error_o   = seq_error_q;

    always_comb begin
        state_d     = state_q;
        fold_d      = fold_q;
        gsr_d       = gsr_q;
        ecg_d       = ecg_q;
        fused_d     = fused_q;
        overflow_d  = overflow_q | (hvin_valid_i & ~hvin_ready_o);
        seq_error_d = seq_error_q;
        case (state_q)
            COLLECT_GSR: if (hvin_valid_i) begin
                gsr_d   = hvin_i;
                // A mistagged beat is still used, placed by our own fold count.
                if (fold_index_i != fold_q) seq_error_d = 1'b1;
                state_d = COLLECT_ECG;
            end
            COLLECT_ECG: if (hvin_valid_i) begin
                ecg_d   = hvin_i;
                state_d = COLLECT_EEG;
            end
            COLLECT_EEG: if (hvin_valid_i) begin
                for (int k = 0; k < NUM_FOLDS; k++) begin
                    if (fold_q == NUM_FOLDS_WIDTH'(k)) fused_d[k*FOLD_WIDTH +: FOLD_WIDTH] = maj;
                end
                if (fold_q == LAST_FOLD) begin
                    fold_d  = '0;
                    state_d = HOLD;
                end else begin
                    fold_d  = fold_q + NUM_FOLDS_WIDTH'(1);
                    state_d = COLLECT_GSR;
                end
            end
            HOLD: if (hvout_ready_i) state_d = COLLECT_GSR;
            default: state_d = COLLECT_GSR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= COLLECT_GSR;
            fold_q      <= '0;
            gsr_q       <= '0;
            ecg_q       <= '0;
            fused_q     <= '0;
            overflow_q  <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fold_q      <= fold_d;
            gsr_q       <= gsr_d;
            ecg_q       <= ecg_d;
            fused_q     <= fused_d;
            overflow_q  <= overflow_d;
            seq_error_q <= seq_error_d;
        end
    end

endmodule
